// File: rtl/period_meter.sv
// Period / high-time meter: synchronizes a slow input, measures clk_in cycles
// between consecutive rising edges and how long the input stayed high.
module period_meter #(
  parameter int COUNT_W = 24,
  parameter int TIMEOUT = 16777215
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] period,
  output logic [COUNT_W-1:0] high_time,
  output logic               period_valid,
  output logic               timeout,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] TIMEOUT_CNT = COUNT_W'(TIMEOUT);
  localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               s1_reg, s2_reg, s3_reg;
  logic [1:0]         fill_reg;
  logic               seen_low_reg;
  logic [COUNT_W-1:0] cnt_reg, cnt_next;
  logic [COUNT_W-1:0] hi_lat_reg, hi_lat_next;
  logic [COUNT_W-1:0] period_reg, period_next;
  logic [COUNT_W-1:0] high_time_reg, high_time_next;
  logic               valid_reg, valid_next;
  logic               timeout_reg, timeout_next;
  logic               busy_reg, busy_next;
  logic               rise, fall;

  // A rise only counts once a genuine low has passed through the synchronizer,
  // so an input already high when reset is released is not taken as an edge.
  assign rise = s2_reg & ~s3_reg & seen_low_reg;
  assign fall = ~s2_reg & s3_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_reg        <= 1'b0;
      s2_reg        <= 1'b0;
      s3_reg        <= 1'b0;
      fill_reg      <= 2'd0;
      seen_low_reg  <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_lat_reg    <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      s1_reg <= sig_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      if (fill_reg != 2'd2) begin
        fill_reg <= fill_reg + 2'd1;
      end
      // s2 holds a real sample of sig_in only after two edges since reset
      if (fill_reg == 2'd2 && !s2_reg) begin
        seen_low_reg <= 1'b1;
      end
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hi_lat_reg    <= hi_lat_next;
      period_reg    <= period_next;
      high_time_reg <= high_time_next;
      valid_reg     <= valid_next;
      timeout_reg   <= timeout_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_lat_next    = hi_lat_reg;
    period_next    = period_reg;
    high_time_next = high_time_reg;
    valid_next     = 1'b0;
    timeout_next   = timeout_reg;

    if (!enable) begin
      state_next  = IDLE;
      cnt_next    = '0;
      hi_lat_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ARM;
        end
        ARM: begin
          if (rise) begin
            state_next  = MEASURE;
            cnt_next    = CNT_ONE;
            hi_lat_next = '0;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle is still a valid measurement
          if (rise) begin
            period_next    = cnt_reg;
            high_time_next = hi_lat_reg;
            valid_next     = 1'b1;
            timeout_next   = 1'b0;
            cnt_next       = CNT_ONE;
            hi_lat_next    = '0;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            timeout_next = 1'b1;
            state_next   = ARM;
            cnt_next     = '0;
            hi_lat_next  = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
            if (fall) begin
              hi_lat_next = cnt_reg;
            end
          end
        end
        default: begin
          state_next  = IDLE;
          cnt_next    = '0;
          hi_lat_next = '0;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign period       = period_reg;
  assign high_time    = high_time_reg;
  assign period_valid = valid_reg;
  assign timeout      = timeout_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, pulses, fastest toggle,
// timeout, enable drop and asynchronous reset with the input held high.
module tb_period_meter;

  localparam int CW = 8;

  logic          clk_in;
  logic          rst;
  logic          sig_in;
  logic          enable;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          timeout;
  logic          busy;

  int errors = 0;
  int checks = 0;

  period_meter #(.COUNT_W(CW), .TIMEOUT(20)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .enable      (enable),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Drive sig_in at a falling edge; outputs read afterwards reflect the previous rising edge.
  task automatic step(input logic s);
    @(negedge clk_in);
    sig_in = s;
  endtask

  task automatic restart_measure();
    step(1'b0); enable = 1'b0;
    step(1'b0); step(1'b0); enable = 1'b1;
    step(1'b0); step(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
    step(1'b0); step(1'b0);
    checks++; if (period !== 8'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL reset_high_time got=%0d exp=0", high_time); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", period_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    step(1'b0); rst = 1'b0;
    step(1'b0); step(1'b0); step(1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_square();
    int n_valid = 0;
    int first_idx = -1;
    step(1'b0); enable = 1'b1;
    step(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL square_arm_busy got=%b exp=1", busy); end
    for (int i = 0; i < 48; i++) begin
      step(((i % 8) < 4) ? 1'b1 : 1'b0);
      if (period_valid === 1'b1) begin
        n_valid++;
        if (first_idx < 0) first_idx = i;
        checks++; if (i != 11 + 8 * (n_valid - 1)) begin errors++; $display("FAIL square_valid_pos got=%0d exp=%0d", i, 11 + 8 * (n_valid - 1)); end
        checks++; if (period !== 8'd8) begin errors++; $display("FAIL square_period got=%0d exp=8", period); end
        checks++; if (high_time !== 8'd4) begin errors++; $display("FAIL square_high got=%0d exp=4", high_time); end
      end
    end
    checks++; if (first_idx != 11) begin errors++; $display("FAIL square_first got=%0d exp=11", first_idx); end
    checks++; if (n_valid != 5) begin errors++; $display("FAIL square_count got=%0d exp=5", n_valid); end
    $display("test_square valids=%0d first=%0d", n_valid, first_idx);
  endtask

  task automatic test_pulse();
    int n_valid = 0;
    restart_measure();
    for (int i = 0; i < 50; i++) begin
      step(((i % 10) < 3) ? 1'b1 : 1'b0);
      if (period_valid === 1'b1) begin
        n_valid++;
        checks++; if (i != 13 + 10 * (n_valid - 1)) begin errors++; $display("FAIL pulse_valid_pos got=%0d exp=%0d", i, 13 + 10 * (n_valid - 1)); end
        checks++; if (period !== 8'd10) begin errors++; $display("FAIL pulse_period got=%0d exp=10", period); end
        checks++; if (high_time !== 8'd3) begin errors++; $display("FAIL pulse_high got=%0d exp=3", high_time); end
      end
    end
    checks++; if (n_valid != 4) begin errors++; $display("FAIL pulse_count got=%0d exp=4", n_valid); end
    $display("test_pulse valids=%0d", n_valid);
  endtask

  task automatic test_toggle();
    int n_valid = 0;
    restart_measure();
    for (int i = 0; i < 20; i++) begin
      step(((i % 2) == 0) ? 1'b1 : 1'b0);
      if (period_valid === 1'b1) begin
        n_valid++;
        checks++; if (i != 5 + 2 * (n_valid - 1)) begin errors++; $display("FAIL toggle_valid_pos got=%0d exp=%0d", i, 5 + 2 * (n_valid - 1)); end
        checks++; if (period !== 8'd2) begin errors++; $display("FAIL toggle_period got=%0d exp=2", period); end
        checks++; if (high_time !== 8'd1) begin errors++; $display("FAIL toggle_high got=%0d exp=1", high_time); end
      end
    end
    checks++; if (n_valid != 8) begin errors++; $display("FAIL toggle_count got=%0d exp=8", n_valid); end
    $display("test_toggle valids=%0d", n_valid);
  endtask

  task automatic test_timeout();
    int early_valid = 0;
    restart_measure();
    for (int i = 0; i < 60; i++) begin
      step((i == 0 || i == 40 || i == 52) ? 1'b1 : 1'b0);
      if (i < 55 && period_valid === 1'b1) early_valid++;
      if (i == 22) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", timeout); end
      end
      if (i == 23) begin
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", timeout); end
      end
      if (i == 30) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy got=%b exp=1", busy); end
        checks++; if (period !== 8'd2) begin errors++; $display("FAIL timeout_period_kept got=%0d exp=2", period); end
      end
      if (i == 54) begin
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout); end
      end
      if (i == 55) begin
        checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL timeout_recover_valid got=%b exp=1", period_valid); end
        checks++; if (period !== 8'd12) begin errors++; $display("FAIL timeout_recover_period got=%0d exp=12", period); end
        checks++; if (high_time !== 8'd1) begin errors++; $display("FAIL timeout_recover_high got=%0d exp=1", high_time); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared got=%b exp=0", timeout); end
      end
    end
    checks++; if (early_valid != 0) begin errors++; $display("FAIL timeout_no_valid got=%0d exp=0", early_valid); end
    $display("test_timeout done");
  endtask

  task automatic test_enable_drop();
    int stray_valid = 0;
    restart_measure();
    for (int i = 0; i < 51; i++) begin
      step(((i % 8) < 4) ? 1'b1 : 1'b0);
      enable = (i < 14 || i >= 27) ? 1'b1 : 1'b0;
      if (i >= 12 && i <= 42 && period_valid === 1'b1) stray_valid++;
      if (i == 11) begin
        checks++; if (period !== 8'd8) begin errors++; $display("FAIL drop_first_period got=%0d exp=8", period); end
      end
      if (i == 15) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", busy); end
      end
      if (i == 20) begin
        checks++; if (period !== 8'd8) begin errors++; $display("FAIL drop_period_kept got=%0d exp=8", period); end
      end
      if (i == 28) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_rearm_busy got=%b exp=1", busy); end
      end
      if (i == 43) begin
        checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL drop_revalid got=%b exp=1", period_valid); end
        checks++; if (high_time !== 8'd4) begin errors++; $display("FAIL drop_high got=%0d exp=4", high_time); end
      end
    end
    checks++; if (stray_valid != 0) begin errors++; $display("FAIL drop_stray_valid got=%0d exp=0", stray_valid); end
    $display("test_enable_drop done");
  endtask

  task automatic test_async_reset();
    int early_valid = 0;
    @(negedge clk_in);
    sig_in = 1'b1;
    checks++; if (period !== 8'd8) begin errors++; $display("FAIL areset_pre_period got=%0d exp=8", period); end
    #2 rst = 1'b1;
    #1;
    checks++; if (period !== 8'd0) begin errors++; $display("FAIL areset_period got=%0d exp=0", period); end
    checks++; if (high_time !== 8'd0) begin errors++; $display("FAIL areset_high got=%0d exp=0", high_time); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", period_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL areset_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    step(1'b1); step(1'b1);
    for (int i = 0; i < 30; i++) begin
      step((i < 6 || (i >= 10 && ((i - 10) % 8) < 4)) ? 1'b1 : 1'b0);
      if (i == 0) rst = 1'b0;
      if (i < 21 && period_valid === 1'b1) early_valid++;
      if (i == 21) begin
        checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL areset_first_valid got=%b exp=1", period_valid); end
        checks++; if (period !== 8'd8) begin errors++; $display("FAIL areset_period_after got=%0d exp=8", period); end
        checks++; if (high_time !== 8'd4) begin errors++; $display("FAIL areset_high_after got=%0d exp=4", high_time); end
      end
    end
    checks++; if (early_valid != 0) begin errors++; $display("FAIL areset_no_false_rise got=%0d exp=0", early_valid); end
    $display("test_async_reset done");
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_square();
    test_pulse();
    test_toggle();
    test_timeout();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
